mips8_mcu: RTL and testbench
============================

MIPS8_MCU -- requirements
Module: mips8_mcu

Interface
REQ-001 Parameter FETCH_BYTES, default 4, number of byte fetches per instruction; legal range 1..4.
REQ-002 Parameter OP_W, default 6, opcode width; only 6 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  OP_W  opcode field of the instruction register; sampled in DECODE.
REQ-006 zero  input  1  ALU zero flag; sampled in BEQEX.
REQ-007 mem_ready  input  1  memory handshake; the current access completes in a cycle where this is high.
REQ-008 irwrite  output  FETCH_BYTES  one-hot instruction-register byte write enable.
REQ-009 pcen  output  1  program counter write enable.
REQ-010 memwrite, lord, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath controls.
REQ-011 alusrcb, pcsrc, aluop  output  2 each  datapath mux and ALU controls.
REQ-012 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, JEX, and ADDIEX/ADDIWB when MIPS8_CU_ADDI_EN is defined.
REQ-014 FETCH, fixed controls: lord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
REQ-015 FETCH, gated by mem_ready: irwrite[bcnt]=mem_ready and pcen=mem_ready.
REQ-016 FETCH, byte counter bcnt advances by 1 on each mem_ready cycle.
REQ-017 FETCH, exit: on mem_ready with bcnt==FETCH_BYTES-1, go to DECODE and clear bcnt to 0.
REQ-018 FETCH with mem_ready low SHALL hold the state and bcnt, with irwrite=0 and pcen=0.
REQ-019 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00 and branch on op.
REQ-020 DECODE next state: 100000->MEMADR, 101000->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000010->JEX, 001000->ADDIEX (macro only).
REQ-021 DECODE with any other op SHALL go to FETCH and assert illegal for exactly that cycle.
REQ-022 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD for op 100000, MEMWR for op 101000.
REQ-023 MEMRD: lord=1; holds until mem_ready, then goes to MEMWB.
REQ-024 MEMWB: regwrite=1, memtoreg=1, regdst=0; then FETCH.
REQ-025 MEMWR: lord=1, memwrite=1 while mem_ready low; goes to FETCH in the mem_ready cycle; memwrite is also high in that cycle.
REQ-026 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; then RTYPEWB.
REQ-027 RTYPEWB: regwrite=1, regdst=1, memtoreg=0; then FETCH.
REQ-028 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero; then FETCH.
REQ-029 JEX: pcsrc=10, pcen=1; then FETCH.
REQ-030 Any output not named for a state SHALL be 0; an unreachable state encoding SHALL go to FETCH.
REQ-031 Instruction latency (cycles, mem_ready tied high): LB FETCH_BYTES+4, SB FETCH_BYTES+3, R-type FETCH_BYTES+3, BEQ/J FETCH_BYTES+2.

Reset
REQ-032 A clock edge with reset high SHALL set state=FETCH and bcnt=0, taking priority over mem_ready.
REQ-033 While reset is high: irwrite, pcen, memwrite, regwrite and illegal SHALL be 0.
REQ-034 Reset asserted mid-instruction, including MEMWR with mem_ready low, SHALL abort the instruction with no further write enable asserted.

Configuration
REQ-035 MIPS8_CU_ADDI_EN defined: op 001000 SHALL take DECODE->ADDIEX->ADDIWB->FETCH.
REQ-036 ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-037 ADDIWB: regwrite=1, regdst=0, memtoreg=0.
REQ-038 MIPS8_CU_ADDI_EN undefined: ADDIEX/ADDIWB do not exist and op 001000 SHALL be illegal (REQ-021).

Structure
REQ-039 Package mips8_pkg SHALL hold the state enum, opcode constants, and the alusrcb/pcsrc/aluop encodings.
REQ-040 The fetch byte counter (bcnt, increment/clear/hold) SHALL be sub-module mips8_byte_ctr, parametrised by FETCH_BYTES.

Verification
REQ-041 Reset mid-fetch: reset for 1 cycle in FETCH with bcnt=2 -> next cycle state FETCH, bcnt=0, irwrite=0000 during reset.
REQ-042 Fetch stall: FETCH_BYTES=4, op=000000, mem_ready pattern 1,0,0,1,1,1 -> irwrite 0001,0000,0000,0010,0100,1000, then DECODE, RTYPEEX, RTYPEWB with regwrite=1, regdst=1.
REQ-043 Store stall: op=101000, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
REQ-044 Branch: op=000100 -> in BEQEX, zero=1 gives pcen=1, pcsrc=01; zero=0 gives pcen=0.
REQ-045 Illegal and ADDI: op=111111 -> illegal=1 for one cycle, then FETCH.
REQ-046 ADDI with macro: op=001000 -> ADDIWB regwrite=1; without the macro -> illegal=1.
REQ-047 Latency with FETCH_BYTES=1, mem_ready=1: LB completes in 5 cycles, J in 3 cycles.

Source files
------------

// File: rtl/mips8_pkg.sv
// mips8_pkg: shared definitions for the MIPS8 multicycle control unit.
//   state_t        - control FSM state encoding (ADDIEX/ADDIWB only when
//                    MIPS8_CU_ADDI_EN is defined)
//   OP_*           - 6-bit opcode constants decoded in DECODE
//   ALUB_*         - alusrcb mux select encodings
//   PCSRC_*        - pcsrc mux select encodings
//   ALUOP_*        - aluop encodings handed to the ALU decoder
//   cnt_w()        - width of the fetch byte counter for a given byte count
package mips8_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9
`ifdef MIPS8_CU_ADDI_EN
    ,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUB_REG  = 2'b00;  // register B
  localparam logic [1:0] ALUB_ONE  = 2'b01;  // constant PC increment
  localparam logic [1:0] ALUB_IMM  = 2'b10;  // immediate
  localparam logic [1:0] ALUB_BOFF = 2'b11;  // branch offset

  localparam logic [1:0] PCSRC_ALU    = 2'b00;  // ALU result (PC+1)
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // registered branch target
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // A single-byte fetch still needs a 1-bit counter to keep ports legal.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips8_byte_ctr.sv
// mips8_byte_ctr: instruction fetch byte counter.
//   clk     - clock
//   reset   - synchronous active-high reset, clears the count
//   inc_i   - a fetch byte completed this cycle
//   bcnt_o  - index of the byte currently being fetched
//   last_o  - bcnt_o addresses the final byte of the instruction
// The count wraps to zero after the final byte so the next instruction
// starts from byte 0 without a separate clear.
module mips8_byte_ctr
  import mips8_pkg::*;
#(
  parameter int FETCH_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inc_i,
  output logic [cnt_w(FETCH_BYTES)-1:0]     bcnt_o,
  output logic                              last_o
);

  localparam int CW = cnt_w(FETCH_BYTES);

  logic [CW-1:0] bcnt_q, bcnt_d;

  assign last_o = (bcnt_q == CW'(FETCH_BYTES - 1));
  assign bcnt_o = bcnt_q;

  always_comb begin
    bcnt_d = bcnt_q;
    if (inc_i) begin
      bcnt_d = last_o ? '0 : bcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/mips8_mcu.sv
// mips8_mcu: multicycle MIPS8 control unit with byte-wide instruction fetch.
// Optional feature: define MIPS8_CU_ADDI_EN to decode ADDI (op 001000).
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   op               - opcode from the instruction register (OP_W must be 6)
//   zero             - ALU zero flag, used by BEQ
//   mem_ready        - memory access completes in a cycle where this is high
//   irwrite          - one-hot instruction register byte write enable
//   pcen             - program counter write enable
//   memwrite, lord, regdst, memtoreg, regwrite, alusrca - datapath controls
//   alusrcb, pcsrc, aluop - 2-bit datapath mux / ALU controls
//   illegal          - one-cycle pulse on an unsupported opcode in DECODE
//   dbg_state_o      - current FSM state
//   dbg_bcnt_o       - current fetch byte index
// Handshake: mem_ready is a ready-only handshake. The controller holds its
// access request (FETCH, MEMRD, MEMWR) with stable controls until a cycle
// with mem_ready high; that cycle completes the access and the FSM advances
// on the following edge. mem_ready is ignored in every other state.
module mips8_mcu
  import mips8_pkg::*;
#(
  parameter int FETCH_BYTES = 4,
  parameter int OP_W        = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OP_W-1:0]               op,
  input  logic                          zero,
  input  logic                          mem_ready,
  output logic [FETCH_BYTES-1:0]        irwrite,
  output logic                          pcen,
  output logic                          memwrite,
  output logic                          lord,
  output logic                          regdst,
  output logic                          memtoreg,
  output logic                          regwrite,
  output logic                          alusrca,
  output logic [1:0]                    alusrcb,
  output logic [1:0]                    pcsrc,
  output logic [1:0]                    aluop,
  output logic                          illegal,
  output state_t                        dbg_state_o,
  output logic [cnt_w(FETCH_BYTES)-1:0] dbg_bcnt_o
);

  localparam int CW = cnt_w(FETCH_BYTES);

  state_t        state_q, state_d;
  logic [CW-1:0] bcnt;
  logic          bcnt_last;
  logic          fetch_inc;

  mips8_byte_ctr #(
    .FETCH_BYTES(FETCH_BYTES)
  ) u_byte_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (fetch_inc),
    .bcnt_o (bcnt),
    .last_o (bcnt_last)
  );

  assign dbg_state_o = state_q;
  assign dbg_bcnt_o  = bcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fetch_inc = 1'b0;
    irwrite   = '0;
    pcen      = 1'b0;
    memwrite  = 1'b0;
    lord      = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = ALUB_REG;
    pcsrc     = PCSRC_ALU;
    aluop     = ALUOP_ADD;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb   = ALUB_ONE;
        fetch_inc = mem_ready;
        pcen      = mem_ready;
        for (int i = 0; i < FETCH_BYTES; i++) begin
          irwrite[i] = mem_ready && (bcnt == CW'(i));
        end
        if (mem_ready && bcnt_last) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = ALUB_BOFF;
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS8_CU_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        // Only LB/SB reach here; the instruction register still holds op.
        state_d = (op == OP_SB) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        lord = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        lord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = zero;
        state_d = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MIPS8_CU_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset aborts whatever is in flight: no write enable may escape while
    // it is asserted, whatever state the register currently holds.
    if (reset) begin
      irwrite  = '0;
      pcen     = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips8_mcu.sv
module tb_mips8_mcu;
  import mips8_pkg::*;

  // Opcodes written out independently of the design package.
  localparam logic [5:0] T_LB   = 6'b100000;
  localparam logic [5:0] T_SB   = 6'b101000;
  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, mr_a, mr_b, zero;
  logic [5:0] op;

  // instance a: FETCH_BYTES=4, instance b: FETCH_BYTES=1
  logic [3:0] irw_a;
  logic [0:0] irw_b;
  logic       pcen_a, mw_a, lord_a, rd_a, m2r_a, rw_a, asa_a, ill_a;
  logic       pcen_b, mw_b, lord_b, rd_b, m2r_b, rw_b, asa_b, ill_b;
  logic [1:0] asb_a, pcs_a, aop_a, asb_b, pcs_b, aop_b;
  state_t     st_a, st_b;
  logic [1:0] bc_a;
  logic [0:0] bc_b;

  mips8_mcu #(.FETCH_BYTES(4), .OP_W(6)) u_dut_a (
    .clk(clk), .reset(rst_a), .op(op), .zero(zero), .mem_ready(mr_a),
    .irwrite(irw_a), .pcen(pcen_a), .memwrite(mw_a), .lord(lord_a),
    .regdst(rd_a), .memtoreg(m2r_a), .regwrite(rw_a), .alusrca(asa_a),
    .alusrcb(asb_a), .pcsrc(pcs_a), .aluop(aop_a), .illegal(ill_a),
    .dbg_state_o(st_a), .dbg_bcnt_o(bc_a)
  );

  mips8_mcu #(.FETCH_BYTES(1), .OP_W(6)) u_dut_b (
    .clk(clk), .reset(rst_b), .op(op), .zero(zero), .mem_ready(mr_b),
    .irwrite(irw_b), .pcen(pcen_b), .memwrite(mw_b), .lord(lord_b),
    .regdst(rd_b), .memtoreg(m2r_b), .regwrite(rw_b), .alusrca(asa_b),
    .alusrcb(asb_b), .pcsrc(pcs_b), .aluop(aop_b), .illegal(ill_b),
    .dbg_state_o(st_b), .dbg_bcnt_o(bc_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  bit          mr_q[$];
  bit          fix_en = 1'b0;
  int          fix_fs[4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packed control vector:
  // {irwrite[3:0], pcen, memwrite, lord, regdst, memtoreg, regwrite,
  //  alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0], illegal}
  function automatic logic [17:0] ctl(input logic [3:0] irw, input bit pc_en, input bit mw,
                                      input bit ld, input bit rd, input bit m2r, input bit rw,
                                      input bit asa, input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic [1:0] aop, input bit ill);
    return {irw, pc_en, mw, ld, rd, m2r, rw, asa, asb, pcs, aop, ill};
  endfunction

  function automatic logic [17:0] obs(input int inst);
    if (inst == 0)
      return {irw_a, pcen_a, mw_a, lord_a, rd_a, m2r_a, rw_a, asa_a, asb_a, pcs_a, aop_a, ill_a};
    return {3'b000, irw_b, pcen_b, mw_b, lord_b, rd_b, m2r_b, rw_b, asa_b, asb_b, pcs_b, aop_b, ill_b};
  endfunction

  function automatic bit legal(input logic [5:0] o);
    bit l;
    l = (o == T_LB) || (o == T_SB) || (o == T_R) || (o == T_BEQ) || (o == T_J);
`ifdef MIPS8_CU_ADDI_EN
    if (o == T_ADDI) l = 1'b1;
`endif
    return l;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit m, input logic [17:0] e);
    mr_q.push_back(m);
    exp_q.push_back(e);
  endtask

  // Reference model: expands one instruction into its per-cycle
  // (mem_ready, expected controls) sequence from the instruction's phases.
  task automatic build(input int fb, input logic [5:0] o, input bit z, input int ms);
    int s;
    bit ill;
    for (int b = 0; b < fb; b++) begin
      s = fix_en ? fix_fs[b] : int'($urandom_range(0, 2));
      repeat (s) push(1'b0, ctl(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
      push(1'b1, ctl(4'(1 << b), 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    end
    ill = !legal(o);
    push(rbit(), ctl(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill));
    if (!ill) begin
      s = (ms < 0) ? int'($urandom_range(0, 2)) : ms;
      if (o == T_LB || o == T_SB)
        push(rbit(), ctl(4'd0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
      if (o == T_LB) begin
        repeat (s) push(1'b0, ctl(4'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        push(1'b1, ctl(4'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        push(rbit(), ctl(4'd0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end else if (o == T_SB) begin
        repeat (s) push(1'b0, ctl(4'd0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        push(1'b1, ctl(4'd0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
      end else if (o == T_R) begin
        push(rbit(), ctl(4'd0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0));
        push(rbit(), ctl(4'd0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end else if (o == T_BEQ) begin
        push(rbit(), ctl(4'd0, z, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
      end else if (o == T_J) begin
        push(rbit(), ctl(4'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0));
      end else begin
        push(rbit(), ctl(4'd0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        push(rbit(), ctl(4'd0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int inst, input string tag);
    bit          m;
    logic [17:0] e;
    while (exp_q.size() > 0) begin
      m = mr_q.pop_front();
      e = exp_q.pop_front();
      if (inst == 0) mr_a = m; else mr_b = m;
      @(negedge clk);
      check(tag, 32'(obs(inst)), 32'(e));
      cyc();
    end
    mr_a = 1'b0;
    mr_b = 1'b0;
    if (inst == 0) begin
      check("idle_state", 32'(st_a), 32'(S_FETCH));
      check("idle_bcnt", 32'(bc_a), 32'd0);
    end else begin
      check("idle_state", 32'(st_b), 32'(S_FETCH));
      check("idle_bcnt", 32'(bc_b), 32'd0);
    end
  endtask

  task automatic run(input int inst, input logic [5:0] o, input bit z, input int ms, input string tag);
    op   = o;
    zero = z;
    build((inst == 0) ? 4 : 1, o, z, ms);
    play(inst, tag);
  endtask

  // Cycles from the first fetch edge until the FSM is back in FETCH,
  // with mem_ready tied high; bounded so a stuck FSM still terminates.
  task automatic lat(input int inst, input logic [5:0] o, input int expc, input string tag);
    int     n;
    bit     left;
    state_t s;
    op   = o;
    zero = 1'b1;
    n    = 0;
    left = 1'b0;
    if (inst == 0) mr_a = 1'b1; else mr_b = 1'b1;
    do begin
      cyc();
      n++;
      s = (inst == 0) ? st_a : st_b;
      if (s != S_FETCH) left = 1'b1;
    end while (!(left && s == S_FETCH) && n < 40);
    mr_a = 1'b0;
    mr_b = 1'b0;
    check(tag, 32'(n), 32'(expc));
  endtask

  logic [5:0] rop;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; mr_a = 1'b0; mr_b = 1'b0;
    zero  = 1'b0; op = T_R;
    cyc();
    mr_a = 1'b1;
    mr_b = 1'b1;
    @(negedge clk);
    check("rst_we_a", 32'(obs(0)), 32'(ctl(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
    check("rst_we_b", 32'(obs(1)), 32'(ctl(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
    cyc();
    mr_a = 1'b0; mr_b = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    check("rst_state", 32'(st_a), 32'(S_FETCH));
    check("rst_bcnt", 32'(bc_a), 32'd0);

    // reset in the middle of a fetch, two bytes already taken
    mr_a = 1'b1;
    cyc(); cyc();
    check("midfetch_bcnt", 32'(bc_a), 32'd2);
    rst_a = 1'b1;
    @(negedge clk);
    check("midfetch_irw", 32'(irw_a), 32'd0);
    check("midfetch_pcen", 32'(pcen_a), 32'd0);
    cyc();
    rst_a = 1'b0;
    check("midfetch_state", 32'(st_a), 32'(S_FETCH));
    check("midfetch_bcnt0", 32'(bc_a), 32'd0);
    @(negedge clk);
    check("midfetch_irw0", 32'(irw_a), 32'd1);
    mr_a = 1'b0;
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;

    // fetch stall pattern 1,0,0,1,1,1 then R-type
    fix_en = 1'b1;
    fix_fs = '{0, 2, 0, 0};
    run(0, T_R, 1'b0, 0, "stall_rtype");
    fix_fs = '{0, 0, 0, 0};
    run(0, T_SB, 1'b0, 3, "store_stall");
    run(0, T_LB, 1'b0, 2, "load_stall");
    run(0, T_BEQ, 1'b1, 0, "beq_taken");
    run(0, T_BEQ, 1'b0, 0, "beq_not");
    run(0, 6'b111111, 1'b0, 0, "illegal");
    run(0, T_ADDI, 1'b0, 0, "addi");
    fix_en = 1'b0;

    // reset while MEMWR is stalled
    op = T_SB;
    mr_a = 1'b1;
    repeat (4) cyc();
    mr_a = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check("memwr_hold", 32'(mw_a), 32'd1);
    cyc();
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_we", 32'({irw_a, pcen_a, mw_a, rw_a, ill_a}), 32'd0);
    cyc();
    rst_a = 1'b0;
    check("abort_state", 32'(st_a), 32'(S_FETCH));
    @(negedge clk);
    check("abort_after", 32'({mw_a, lord_a}), 32'd0);
    cyc();

    // latency, mem_ready tied high
    lat(0, T_LB, 8, "lat4_lb");
    lat(0, T_SB, 7, "lat4_sb");
    lat(0, T_R, 7, "lat4_r");
    lat(0, T_J, 6, "lat4_j");
    lat(1, T_LB, 5, "lat1_lb");
    lat(1, T_J, 3, "lat1_j");
    lat(1, T_BEQ, 3, "lat1_beq");

    // randomized instruction stream on both configurations
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0: rop = T_LB;
        1: rop = T_SB;
        2: rop = T_R;
        3: rop = T_BEQ;
        4: rop = T_J;
        5: rop = T_ADDI;
        6: rop = 6'b111111;
        default: rop = 6'($urandom);
      endcase
      run((k < 40) ? 0 : 1, rop, rbit(), -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
